w10_output_classifier: RTL and testbench

Output-layer sequencer and classifier for the ELM digit recogniser. For each of the N_CLS output classes it drives the hidden-neuron loop counter (W10loop_rst/adv) and fetches one hidden activation and one output weight per index. It multiply-accumulates their products into a class score and keeps a running argmax. When all classes are scored it reports the winning digit and its score.

---
 rtl/w10_output_classifier.sv | 111 +++++++++++
 tb/tb_w10_output_classifier.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/w10_output_classifier.sv
// w10_output_classifier: ELM output-layer sequencer, per-class MAC scoring and running argmax
module w10_output_classifier #(
   parameter int N_HID   = 40,
   parameter int N_CLS   = 10,
   parameter int DW      = 16,
   parameter int WW      = 16,
   parameter int AW      = 40,
   parameter int MUL_LAT = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [5:0]           W10loop,
   output logic                 W10loop_rst,
   output logic                 adv,
   output logic [5:0]           hid_addr,
   output logic [9:0]           w_addr,
   input  logic signed [DW-1:0] hid_data,
   input  logic signed [WW-1:0] w_data,
   output logic                 busy,
   output logic                 done,
   output logic [3:0]           digit,
   output logic signed [AW-1:0] max_score
);
   localparam int PW = DW + WW;
   typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, CMP, DONE} state_t;
   state_t state;
   logic [3:0] cls;
   logic [MUL_LAT:0] vld;
   logic signed [DW-1:0] hid_q;
   logic signed [WW-1:0] w_q;
   logic signed [PW-1:0] prod_c, prod;
   logic signed [AW-1:0] acc;
   assign W10loop_rst = state == IDLE || state == CLR;
   assign adv = state == RUN && W10loop < 6'(N_HID);
   assign hid_addr = W10loop - 6'd1;
   assign w_addr = 10'(cls) * 10'(N_HID) + 10'(W10loop) - 10'd1;
   assign prod_c = hid_q * w_q;
   if (MUL_LAT == 1) begin : g_nopipe
      assign prod = prod_c;
   end else begin : g_pipe
      logic signed [PW-1:0] pr [MUL_LAT-1];
      // product register chain between the data stage and the accumulator
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < MUL_LAT-1; i++) pr[i] <= '0;
         end else begin
            pr[0] <= prod_c;
            for (int i = 1; i < MUL_LAT-1; i++) pr[i] <= pr[i-1];
         end
      end
      assign prod = pr[MUL_LAT-2];
   end
   // vld[0] marks the cycle the RAM/ROM data is valid; data stage captures operands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         hid_q <= '0;
         w_q <= '0;
      end else begin
         vld <= {vld[MUL_LAT-1:0], state == RUN};
         hid_q <= hid_data;
         w_q <= w_data;
      end
   end
   // sequencer, accumulator and argmax; DRAIN ends when only the final product remains in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cls <= '0;
         acc <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         digit <= '0;
         max_score <= '0;
      end else begin
         done <= 1'b0;
         if (vld[MUL_LAT]) acc <= acc + {{(AW-PW){prod[PW-1]}}, prod};
         case (state)
            IDLE: if (start) begin
               state <= CLR;
               cls <= '0;
               busy <= 1'b1;
            end
            CLR: begin
               acc <= '0;
               state <= RUN;
            end
            RUN: if (W10loop >= 6'(N_HID)) state <= DRAIN;
            DRAIN: if (vld == {1'b1, {MUL_LAT{1'b0}}}) state <= CMP;
            CMP: begin
               if (cls == 4'd0 || acc > max_score) begin
                  max_score <= acc;
                  digit <= cls;
               end
               if (cls == 4'(N_CLS-1)) state <= DONE;
               else begin
                  cls <= cls + 4'd1;
                  state <= CLR;
               end
            end
            DONE: begin
               done <= 1'b1;
               busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_w10_output_classifier.sv
// tb_w10_output_classifier: directed scoring scenarios checked against an arithmetic argmax model
module tb_w10_output_classifier;
   localparam int N_HID = 40, N_CLS = 10, DW = 16, WW = 16, AW = 40, MUL_LAT = 2;
   logic clk = 0, rst_n = 0, start = 0;
   logic [5:0] W10loop = 6'd37;
   logic W10loop_rst, adv, busy, done;
   logic [5:0] hid_addr;
   logic [9:0] w_addr;
   logic signed [DW-1:0] hid_data = '0;
   logic signed [WW-1:0] w_data = '0;
   logic [3:0] digit;
   logic signed [AW-1:0] max_score;
   logic signed [DW-1:0] hid_mem [64];
   logic signed [WW-1:0] w_mem [1024];
   int n_vec = 0, n_bad = 0, n_done = 0, mon_clr = 0, mon_adv = 0, exp_idx = 1;
   logic prev_adv = 0;
   logic [3:0] exp_digit = '0;
   logic signed [AW-1:0] exp_score = '0;

   w10_output_classifier #(.N_HID(N_HID), .N_CLS(N_CLS), .DW(DW), .WW(WW), .AW(AW), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .W10loop(W10loop), .W10loop_rst(W10loop_rst),
      .adv(adv), .hid_addr(hid_addr), .w_addr(w_addr), .hid_data(hid_data), .w_data(w_data),
      .busy(busy), .done(done), .digit(digit), .max_score(max_score));

   always #5 clk = ~clk;

   // loop counter plus one-cycle-latency activation RAM and weight ROM
   always @(posedge clk) begin
      W10loop <= W10loop_rst ? 6'd1 : adv ? W10loop + 6'd1 : W10loop;
      hid_data <= hid_mem[hid_addr];
      w_data <= w_mem[w_addr];
   end

   task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask

   task automatic fill(input int kind);
      for (int i = 0; i < 64; i++) hid_mem[i] = '0;
      for (int i = 0; i < 1024; i++) w_mem[i] = '0;
      for (int c = 0; c < N_CLS; c++)
         for (int i = 0; i < N_HID; i++) begin
            case (kind)
               1: begin hid_mem[i] = 16'sd1; if (c == 7) w_mem[c*N_HID+i] = 16'sd1; end
               2: begin
                  hid_mem[i] = 16'sd1;
                  if (c == 2 && i == 0) w_mem[c*N_HID+i] = 16'sd100;
                  if (c == 5 && i < 20) w_mem[c*N_HID+i] = 16'sd5;
                  if (c == 3 && i == 0) w_mem[c*N_HID+i] = 16'sd99;
               end
               3: begin hid_mem[i] = 16'sd1; if (i < 10) w_mem[c*N_HID+i] = WW'(-(c+1)); end
               4: begin hid_mem[i] = -16'sd32768; w_mem[c*N_HID+i] = -16'sd32768; end
               default: begin hid_mem[i] = DW'(i - 20); w_mem[c*N_HID+i] = WW'((c*7 + i*3) % 17 - 8); end
            endcase
         end
   endtask

   // expected result: dot product per class, wrapped to AW bits, strict signed argmax
   task automatic model();
      longint sum;
      logic signed [AW-1:0] s;
      for (int c = 0; c < N_CLS; c++) begin
         sum = 0;
         for (int i = 0; i < N_HID; i++) sum += longint'(hid_mem[i]) * longint'(w_mem[c*N_HID+i]);
         s = sum[AW-1:0];
         if (c == 0 || s > exp_score) begin
            exp_score = s;
            exp_digit = 4'(c);
         end
      end
   endtask

   task automatic run_test(input int kind, input bit extra, input bit pin, input int pd, input longint ps);
      int e, d0;
      fill(kind);
      model();
      if (pin) begin
         chk("model_digit", exp_digit, pd);
         chk("model_score", exp_score, ps);
      end
      d0 = n_done;
      @(negedge clk) start = 1;
      @(negedge clk) start = 0;
      e = 0;
      while (!done && e < 1000) begin
         @(negedge clk);
         e++;
         start = extra && (e == 5 || e == 200);
         if (extra && e == 200) chk("busy_mid", busy, 1);
      end
      start = 0;
      chk("latency", e, 451);
      chk("busy_at_done", busy, 0);
      if (pin) begin
         chk("digit", digit, pd);
         chk("score", max_score, ps);
      end
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("single_done", n_done, d0 + 1);
      repeat (3) @(negedge clk);
      chk("digit_hold", digit, exp_digit);
      chk("score_hold", max_score, exp_score);
   endtask

   initial begin
      int e, d0;
      fork
         forever begin
            @(negedge clk);
            if (rst_n && busy) begin
               if (W10loop_rst) begin mon_clr++; exp_idx = 1; end
               if (adv || prev_adv) begin
                  chk("issue_idx", W10loop, exp_idx);
                  chk("hid_addr", hid_addr, exp_idx - 1);
                  chk("w_addr", w_addr, (mon_clr - 1) * N_HID + exp_idx - 1);
                  if (adv) begin exp_idx++; mon_adv++; end
               end
            end
            if (rst_n && done) begin
               chk("done_digit", digit, exp_digit);
               chk("done_score", max_score, exp_score);
               chk("clr_pulses", mon_clr, N_CLS);
               chk("adv_cycles", mon_adv, N_CLS * (N_HID - 1));
               n_done++;
            end
            if (!busy) begin mon_clr = 0; mon_adv = 0; end
            prev_adv = adv && busy && rst_n;
         end
      join_none
      #12;
      chk("rst_loop_rst", W10loop_rst, 1);
      chk("rst_adv", adv, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_digit", digit, 0);
      chk("rst_score", max_score, 0);
      @(negedge clk) rst_n = 1;
      repeat (2) @(negedge clk);
      run_test(1, 1, 1, 7, 40);
      run_test(2, 0, 1, 2, 100);
      run_test(3, 0, 1, 0, -10);
      run_test(4, 0, 1, 0, 64'sd42949672960);
      run_test(5, 0, 0, 0, 0);
      fill(3);
      d0 = n_done;
      @(negedge clk) start = 1;
      @(negedge clk) start = 0;
      e = 0;
      while (mon_clr < 5 && e < 1000) begin @(negedge clk); e++; end
      chk("reach_cls4", mon_clr, 5);
      repeat (10) @(negedge clk);
      chk("pre_rst_score", max_score, -10);
      #2 rst_n = 0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_digit", digit, 0);
      chk("arst_score", max_score, 0);
      chk("arst_loop_rst", W10loop_rst, 1);
      chk("arst_adv", adv, 0);
      repeat (3) @(negedge clk);
      rst_n = 1;
      repeat (2) @(negedge clk);
      chk("no_done_after_rst", n_done, d0);
      run_test(1, 0, 1, 7, 40);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
